// File: rtl/vga_timing_gen.sv
// VGA timing generator: waits for a stable PLL lock, then sweeps x/y over the
// full raster and decodes sync, display-enable and start pulses with zero latency.
module vga_timing_gen #(
  parameter int   H_VISIBLE   = 640,
  parameter int   H_FRONT     = 16,
  parameter int   H_SYNC      = 96,
  parameter int   H_BACK      = 48,
  parameter int   V_VISIBLE   = 480,
  parameter int   V_FRONT     = 10,
  parameter int   V_SYNC      = 2,
  parameter int   V_BACK      = 33,
  parameter logic SYNC_ACTIVE = 1'b0,
  parameter int   LOCK_DELAY  = 1024,
  parameter int   CW          = 10
) (
  input  logic          global_clock,
  input  logic          resetb,
  input  logic          locked,
  output logic          hsync,
  output logic          vsync,
  output logic          display_enable,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          line_start,
  output logic          frame_start,
  output logic          running
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int SW      = (LOCK_DELAY > 1) ? $clog2(LOCK_DELAY) : 1;

  localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] ONE    = CW'(1);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(LOCK_DELAY - 1);
  localparam logic [SW-1:0] SETTLE_ONE  = SW'(1);

  // Decode bounds carry one spare bit so a sync window ending at 2^CW still compares correctly
  localparam logic [CW:0] H_VIS_END  = (CW+1)'(H_VISIBLE);
  localparam logic [CW:0] H_SYNC_BEG = (CW+1)'(H_VISIBLE + H_FRONT);
  localparam logic [CW:0] H_SYNC_END = (CW+1)'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [CW:0] V_VIS_END  = (CW+1)'(V_VISIBLE);
  localparam logic [CW:0] V_SYNC_BEG = (CW+1)'(V_VISIBLE + V_FRONT);
  localparam logic [CW:0] V_SYNC_END = (CW+1)'(V_VISIBLE + V_FRONT + V_SYNC);

  typedef enum logic {
    WAIT_LOCK = 1'b0,
    RUN       = 1'b1
  } state_t;

  state_t        state_r;
  logic [SW-1:0] settle_r;
  logic [CW-1:0] x_nxt_s;
  logic [CW-1:0] y_nxt_s;
  logic [CW:0]   xw_s;
  logic [CW:0]   yw_s;
  logic          load_s;
  logic          de_s;
  logic          hs_s;
  logic          vs_s;

  // Next raster position and its decode; entering RUN starts from the origin
  always_comb begin
    x_nxt_s = '0;
    y_nxt_s = '0;
    if (state_r == RUN) begin
      if (x == H_LAST) begin
        x_nxt_s = '0;
        if (y == V_LAST) begin
          y_nxt_s = '0;
        end else begin
          y_nxt_s = y + ONE;
        end
      end else begin
        x_nxt_s = x + ONE;
        y_nxt_s = y;
      end
    end else begin
      x_nxt_s = '0;
      y_nxt_s = '0;
    end
    xw_s   = {1'b0, x_nxt_s};
    yw_s   = {1'b0, y_nxt_s};
    de_s   = (xw_s < H_VIS_END) && (yw_s < V_VIS_END);
    hs_s   = ((xw_s >= H_SYNC_BEG) && (xw_s < H_SYNC_END)) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    vs_s   = ((yw_s >= V_SYNC_BEG) && (yw_s < V_SYNC_END)) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    load_s = locked && ((state_r == RUN) || (settle_r == SETTLE_LAST));
  end

  // Lock-settle state machine
  always_ff @(posedge global_clock) begin
    if (!resetb) begin
      state_r  <= WAIT_LOCK;
      settle_r <= '0;
    end else begin
      case (state_r)
        WAIT_LOCK: begin
          if (!locked) begin
            settle_r <= '0;
          end else if (settle_r == SETTLE_LAST) begin
            state_r  <= RUN;
            settle_r <= '0;
          end else begin
            settle_r <= settle_r + SETTLE_ONE;
          end
        end
        RUN: begin
          if (!locked) begin
            state_r  <= WAIT_LOCK;
            settle_r <= '0;
          end else begin
            state_r  <= RUN;
          end
        end
        default: begin
          state_r  <= WAIT_LOCK;
          settle_r <= '0;
        end
      endcase
    end
  end

  // Registered timing outputs; anything other than an active RUN cycle shows idle values
  always_ff @(posedge global_clock) begin
    if (resetb && load_s) begin
      x              <= x_nxt_s;
      y              <= y_nxt_s;
      display_enable <= de_s;
      hsync          <= hs_s;
      vsync          <= vs_s;
      line_start     <= (x_nxt_s == '0);
      frame_start    <= (x_nxt_s == '0) && (y_nxt_s == '0);
      running        <= 1'b1;
    end else begin
      x              <= '0;
      y              <= '0;
      display_enable <= 1'b0;
      hsync          <= ~SYNC_ACTIVE;
      vsync          <= ~SYNC_ACTIVE;
      line_start     <= 1'b0;
      frame_start    <= 1'b0;
      running        <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen on a reduced raster: a linear frame-position
// model predicts every output cycle, and a negedge monitor compares against it.
module tb_vga_timing_gen;

  localparam int HV = 64, HF = 8, HS = 12, HB = 6;
  localparam int VV = 48, VF = 3, VS = 2, VB = 4;
  localparam int HT = HV + HF + HS + HB;
  localparam int VT = VV + VF + VS + VB;
  localparam int LD = 1024;
  localparam int CW = 10;

  logic          clk = 1'b0;
  logic          resetb = 1'b0;
  logic          locked = 1'b0;
  logic          hsync, vsync, display_enable, line_start, frame_start, running;
  logic [CW-1:0] x, y;

  typedef struct packed {
    logic          hs;
    logic          vs;
    logic          de;
    logic [CW-1:0] x;
    logic [CW-1:0] y;
    logic          ls;
    logic          fs;
    logic          run;
  } obs_t;

  obs_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Model: "running" flag, count of consecutive locked samples, linear position in frame
  bit m_run    = 1'b0;
  int m_streak = 0;
  int m_t      = 0;

  vga_timing_gen #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .SYNC_ACTIVE(1'b0), .LOCK_DELAY(LD), .CW(CW)
  ) dut (
    .global_clock(clk), .resetb(resetb), .locked(locked),
    .hsync(hsync), .vsync(vsync), .display_enable(display_enable),
    .x(x), .y(y), .line_start(line_start), .frame_start(frame_start),
    .running(running)
  );

  always #5 clk = ~clk;

  function automatic obs_t expect_now();
    obs_t o;
    int   px, py;
    o = '0;
    o.hs = 1'b1;
    o.vs = 1'b1;
    if (m_run) begin
      px    = m_t % HT;
      py    = m_t / HT;
      o.x   = CW'(px);
      o.y   = CW'(py);
      o.de  = (px < HV) && (py < VV);
      o.hs  = !((px >= HV + HF) && (px < HV + HF + HS));
      o.vs  = !((py >= VV + VF) && (py < VV + VF + VS));
      o.ls  = (px == 0);
      o.fs  = (m_t == 0);
      o.run = 1'b1;
    end
    return o;
  endfunction

  task automatic step(input logic r, input logic l);
    resetb = r;
    locked = l;
    if (!r) begin
      m_run    = 1'b0;
      m_streak = 0;
    end else if (!m_run) begin
      if (l) begin
        m_streak++;
        if (m_streak == LD) begin
          m_run    = 1'b1;
          m_t      = 0;
          m_streak = 0;
        end
      end else begin
        m_streak = 0;
      end
    end else if (!l) begin
      m_run    = 1'b0;
      m_streak = 0;
    end else begin
      m_t = (m_t + 1) % (HT * VT);
    end
    @(posedge clk);
    #1;
    sb.push_back(expect_now());
  endtask

  // Advance with lock held until the model sits at (tx,ty); bounded
  task automatic run_to(input int tx, input int ty);
    int n;
    n = 0;
    while (!(m_run && m_t == ty * HT + tx) && n < 3 * HT * VT + 2 * LD) begin
      step(1'b1, 1'b1);
      n++;
    end
    checks++;
    if (!(m_run && m_t == ty * HT + tx)) begin
      errors++;
      $display("FAIL run_to: position x=%0d y=%0d not reached, required target x=%0d y=%0d", m_t % HT, m_t / HT, tx, ty);
    end
  endtask

  // Monitor: one scoreboard entry per clock, compared away from the active edge
  always @(negedge clk) begin
    obs_t e, a;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      a = '{hs: hsync, vs: vsync, de: display_enable, x: x, y: y,
            ls: line_start, fs: frame_start, run: running};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL outputs @%0t: got hs=%b vs=%b de=%b x=%0d y=%0d ls=%b fs=%b run=%b required hs=%b vs=%b de=%b x=%0d y=%0d ls=%b fs=%b run=%b",
                 $time, a.hs, a.vs, a.de, a.x, a.y, a.ls, a.fs, a.run,
                 e.hs, e.vs, e.de, e.x, e.y, e.ls, e.fs, e.run);
      end
    end
  end

  initial begin
    // Settle from reset, then two full frames
    repeat (4) step(1'b0, 1'b1);
    repeat (LD + 2 * HT * VT + 10) step(1'b1, 1'b1);

    // Settle interruption
    step(1'b0, 1'b1);
    repeat (500) step(1'b1, 1'b1);
    step(1'b1, 1'b0);
    repeat (LD + 50) step(1'b1, 1'b1);

    // Lock loss mid-frame, then re-lock
    run_to(30, 20);
    step(1'b1, 1'b0);
    repeat (LD + 300) step(1'b1, 1'b1);

    // Reset mid-frame inside the sync regions, with lock held
    run_to(75, 52);
    step(1'b0, 1'b1);
    repeat (LD + 200) step(1'b1, 1'b1);

    // Reset and lock drop together
    step(1'b0, 1'b0);
    repeat (LD + 5) step(1'b1, 1'b1);

    // Randomised lock glitches and resets
    for (int i = 0; i < 20000; i++) begin
      step(($urandom_range(0, 4999) != 0) ? 1'b1 : 1'b0,
           ($urandom_range(0, 2499) != 0) ? 1'b1 : 1'b0);
    end

    @(negedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending entries, required 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
